// File: rtl/fnd_scan_ctrl.sv
// Scan controller for a multi-digit common-anode 7-segment display sharing one decoder.
// Sequences digit commons with a blanking guard and swaps in new values only at frame boundaries.
module fnd_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_CYC  = 16
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst_n,
   input  logic                    i_Valid,
   input  logic [4*NUM_DIGITS-1:0] i_Data,
   output logic                    o_Ready,
   input  logic                    i_Blank_Lz,
   output logic [3:0]              o_Num,
   output logic [NUM_DIGITS-1:0]   o_Com,
   output logic                    o_Digit_En,
   output logic                    o_Frame_Done
);

   // state   | meaning
   // S_BLANK | all commons off, o_Num already holds the upcoming digit
   // S_SHOW  | common of the current digit on (unless leading-zero blanked)

   localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   localparam logic [0:0] S_BLANK = 1'b0;
   localparam logic [0:0] S_SHOW  = 1'b1;

   logic [0:0]              state_q, state_nx;
   logic [CNT_W-1:0]        cnt_q, cnt_nx;
   logic [IDX_W-1:0]        idx_q, idx_nx;
   logic [4*NUM_DIGITS-1:0] active_q, pend_q;
   logic                    boundary, load_num, accept, zero_above;
   logic [NUM_DIGITS-1:0]   lz_blank, com_nx;
   logic [3:0]              num_nx;

   assign accept = i_Valid & o_Ready;

   // A digit is blankable when it and every more-significant nibble are zero.
   always_comb begin
      lz_blank   = '0;
      zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         zero_above  = zero_above & (active_q[4*k +: 4] == 4'h0);
         lz_blank[k] = zero_above;
      end
   end

   always_comb begin
      state_nx = state_q;
      cnt_nx   = cnt_q + 1'b1;
      idx_nx   = idx_q;
      load_num = 1'b0;
      boundary = 1'b0;
      case (state_q)
         S_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_nx = S_SHOW;
               cnt_nx   = '0;
            end
         end
         default: begin
            if (cnt_q == SHOW_LAST) begin
               state_nx = S_BLANK;
               cnt_nx   = '0;
               load_num = 1'b1;
               if (idx_q == IDX_LAST) begin
                  idx_nx   = '0;
                  boundary = 1'b1;
               end else begin
                  idx_nx = idx_q + 1'b1;
               end
            end
         end
      endcase
   end

   // Digit 0 of a new frame must come from the value being transferred on this edge.
   always_comb begin
      num_nx = o_Num;
      if (load_num) begin
         if (boundary && !o_Ready) begin
            num_nx = pend_q[3:0];
         end else begin
            num_nx = active_q[{idx_nx, 2'b00} +: 4];
         end
      end
   end

   always_comb begin
      com_nx = '1;
      if (state_nx == S_SHOW && !(i_Blank_Lz && lz_blank[idx_nx])) begin
         com_nx[idx_nx] = 1'b0;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q      <= S_BLANK;
         cnt_q        <= '0;
         idx_q        <= '0;
         active_q     <= '0;
         pend_q       <= '0;
         o_Ready      <= 1'b1;
         o_Num        <= 4'h0;
         o_Com        <= '1;
         o_Digit_En   <= 1'b0;
         o_Frame_Done <= 1'b0;
      end else begin
         state_q      <= state_nx;
         cnt_q        <= cnt_nx;
         idx_q        <= idx_nx;
         o_Num        <= num_nx;
         o_Com        <= com_nx;
         o_Digit_En   <= ~&com_nx;
         o_Frame_Done <= boundary;
         // o_Ready low means the pending buffer is full, so no accept can race the transfer.
         if (boundary && !o_Ready) begin
            active_q <= pend_q;
            o_Ready  <= 1'b1;
         end else if (accept) begin
            pend_q  <= i_Data;
            o_Ready <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: stimulus queues per-cycle expectations, a monitor checks them.
module tb_fnd_scan_ctrl;

   logic        clk, rst_n, valid, lz;
   logic [15:0] data;
   logic        ready, digit_en, frame_done;
   logic [3:0]  num, com;

   int checks = 0;
   int errors = 0;
   int cyc;

   typedef struct {
      int         cyc;
      logic [3:0] com;
      logic [3:0] num;
      logic       en;
      logic       fd;
   } disp_t;

   typedef struct {
      int   cyc;
      logic rdy;
   } rdy_t;

   disp_t dq[$];
   rdy_t  rq[$];
   disp_t me;
   rdy_t  mr;

   fnd_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(2)) dut (
      .i_Clk        (clk),
      .i_Rst_n      (rst_n),
      .i_Valid      (valid),
      .i_Data       (data),
      .o_Ready      (ready),
      .i_Blank_Lz   (lz),
      .o_Num        (num),
      .o_Com        (com),
      .o_Digit_En   (digit_en),
      .o_Frame_Done (frame_done)
   );

   always #5 clk = ~clk;

   // cycle k = after k rising edges since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         while (dq.size() > 0 && dq[0].cyc < cyc) begin
            me = dq.pop_front();
            checks++;
            errors++;
            $display("FAIL disp_missed: expectation for cycle %0d never compared (now %0d)", me.cyc, cyc);
         end
         if (dq.size() > 0 && dq[0].cyc == cyc) begin
            me = dq.pop_front();
            checks++;
            if (com !== me.com || num !== me.num || digit_en !== me.en || frame_done !== me.fd) begin
               errors++;
               $display("FAIL disp cyc=%0d: got com=%b num=%h en=%b fd=%b, want com=%b num=%h en=%b fd=%b",
                        cyc, com, num, digit_en, frame_done, me.com, me.num, me.en, me.fd);
            end
         end
         while (rq.size() > 0 && rq[0].cyc < cyc) begin
            mr = rq.pop_front();
            checks++;
            errors++;
            $display("FAIL ready_missed: expectation for cycle %0d never compared (now %0d)", mr.cyc, cyc);
         end
         if (rq.size() > 0 && rq[0].cyc == cyc) begin
            mr = rq.pop_front();
            checks++;
            if (ready !== mr.rdy) begin
               errors++;
               $display("FAIL ready cyc=%0d: got %b, want %b", cyc, ready, mr.rdy);
            end
         end
      end
   end

   // One frame = 4 slots of (2 blank + 4 show) cycles.
   task automatic push_frame(input int f, input logic [15:0] val, input logic lzb);
      disp_t      e;
      logic [3:0] one;
      logic       blanked;
      logic [15:0] upper;
      one = 4'b0001;
      for (int d = 0; d < 4; d++) begin
         upper   = val >> (4 * d);
         blanked = lzb && (d != 0) && (upper == 16'h0);
         for (int c = 0; c < 6; c++) begin
            e.cyc = 24 * f + 6 * d + c;
            e.num = upper[3:0];
            e.en  = (c >= 2) && !blanked;
            e.com = e.en ? ~(one << d) : 4'hF;
            e.fd  = (f > 0) && (d == 0) && (c == 0);
            dq.push_back(e);
         end
      end
   endtask

   task automatic push_rdy(input int from, input int to, input logic v);
      rdy_t r;
      for (int i = from; i <= to; i++) begin
         r.cyc = i;
         r.rdy = v;
         rq.push_back(r);
      end
   endtask

   task automatic at_cycle(input int n);
      int guard;
      guard = 0;
      while (cyc != n && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (cyc != n) begin
         errors++;
         $display("FAIL at_cycle: waited for cycle %0d, reached %0d", n, cyc);
      end
   endtask

   task automatic check_reset(input string name);
      checks++;
      if (com !== 4'hF || num !== 4'h0 || ready !== 1'b1 || frame_done !== 1'b0 || digit_en !== 1'b0) begin
         errors++;
         $display("FAIL %s: got com=%b num=%h rdy=%b fd=%b en=%b, want com=1111 num=0 rdy=1 fd=0 en=0",
                  name, com, num, ready, frame_done, digit_en);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      clk   = 1'b0;
      rst_n = 1'b0;
      valid = 1'b0;
      data  = 16'h0;
      lz    = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset("reset_hold");

      push_frame(0, 16'h0000, 1'b0);
      push_frame(1, 16'h1234, 1'b0);
      push_frame(2, 16'h1111, 1'b0);
      push_frame(3, 16'h2222, 1'b0);
      push_frame(4, 16'h2222, 1'b0);
      push_frame(5, 16'h0050, 1'b1);
      push_frame(6, 16'h0000, 1'b1);
      push_frame(7, 16'h0A00, 1'b1);
      push_rdy(0, 10, 1'b1);
      push_rdy(11, 23, 1'b0);
      push_rdy(24, 30, 1'b1);
      push_rdy(31, 47, 1'b0);
      push_rdy(48, 48, 1'b1);
      push_rdy(49, 71, 1'b0);
      push_rdy(72, 95, 1'b1);
      push_rdy(96, 119, 1'b0);
      push_rdy(120, 125, 1'b1);
      push_rdy(126, 143, 1'b0);
      push_rdy(144, 150, 1'b1);
      push_rdy(151, 167, 1'b0);
      push_rdy(168, 175, 1'b1);
      push_rdy(176, 183, 1'b0);

      @(posedge clk);
      #1 rst_n = 1'b1;

      at_cycle(10);  valid = 1'b1; data = 16'h1234;
      at_cycle(11);  valid = 1'b0;
      at_cycle(30);  valid = 1'b1; data = 16'h1111;
      at_cycle(31);  data  = 16'h2222;
      at_cycle(49);  valid = 1'b0;
      at_cycle(95);  valid = 1'b1; data = 16'h0050;
      at_cycle(96);  valid = 1'b0;
      at_cycle(100); lz    = 1'b1;
      at_cycle(125); valid = 1'b1; data = 16'h0000;
      at_cycle(126); valid = 1'b0;
      at_cycle(150); valid = 1'b1; data = 16'h0A00;
      at_cycle(151); valid = 1'b0;
      at_cycle(175); valid = 1'b1; data = 16'h9876;
      at_cycle(176); valid = 1'b0;

      // digit 2 is mid-show here with 9876 pending
      at_cycle(183);
      #2 rst_n = 1'b0;
      #1 check_reset("async_reset");
      dq.delete();
      rq.delete();
      lz = 1'b0;
      repeat (2) @(posedge clk);
      push_frame(0, 16'h0000, 1'b0);
      push_frame(1, 16'h0000, 1'b0);
      push_rdy(0, 47, 1'b1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      guard = 0;
      while ((dq.size() > 0 || rq.size() > 0) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      checks++;
      if (dq.size() > 0 || rq.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d display and %0d ready expectations left, want 0", dq.size(), rq.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode 7-segment (FND) display that shares one 4-bit-to-7-segment decoder across all digits. It sequences digit commons, drives the shared decoder's 4-bit nibble input, and inserts a blanking guard between digits to suppress ghosting. It also accepts new display values through a valid/ready handshake and applies them atomically at frame boundaries. It sits between the counter/datapath logic that produces BCD/hex values and the board-level FND decoder plus digit drivers.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal 1..8.
SCAN_DIV, 50000, clock cycles each digit is shown; legal >= 2.
BLANK_CYC, 16, clock cycles with all commons off before each digit; legal >= 1.

Ports:
i_Clk  input  1  system clock, all state on rising edge.
i_Rst_n  input  1  asynchronous active-low reset.
i_Valid  input  1  new display value offered on i_Data.
i_Data  input  4*NUM_DIGITS  packed nibbles; [3:0] = digit 0 (least significant).
o_Ready  output  1  pending buffer empty; a transfer happens when i_Valid & o_Ready.
i_Blank_Lz  input  1  leading-zero blanking enable, sampled every cycle.
o_Num  output  4  nibble to the shared FND decoder.
o_Com  output  NUM_DIGITS  digit commons, active-low, one-hot-low or all ones.
o_Digit_En  output  1  high while some o_Com bit is low.
o_Frame_Done  output  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Clock is i_Clk. Reset is i_Rst_n: asynchronous assert, active-low. All outputs are registered.
- Reset values: o_Com all ones, o_Num 0, o_Digit_En 0, o_Frame_Done 0, o_Ready 1.
- Reset values of internal state: active register 0, pending empty, digit index 0, state S_BLANK, counter 0.
- Slot timing: each digit slot is BLANK_CYC cycles in S_BLANK followed by SCAN_DIV cycles in S_SHOW. A frame is NUM_DIGITS*(BLANK_CYC+SCAN_DIV) cycles.
- Scan order: index 0 first, then ascending; after NUM_DIGITS-1 the index wraps to 0.
- S_BLANK:
  - o_Com all ones, o_Digit_En 0.
  - o_Num already holds the current digit's nibble, loaded on entry, so the decoder settles before the common turns on.
  - After BLANK_CYC cycles, go to S_SHOW.
- S_SHOW:
  - o_Com[idx] is 0 unless the digit is LZ-blanked, in which case all bits stay 1.
  - o_Digit_En equals the inverse of the AND of all o_Com bits.
  - After SCAN_DIV cycles, go to S_BLANK with idx+1 and load o_Num with the next nibble.
- Frame boundary: the S_SHOW→S_BLANK transition leaving idx NUM_DIGITS-1.
  - o_Frame_Done is 1 for exactly the first cycle of the following blank.
  - If pending is full, the active register takes pending in the same edge, and pending clears.
  - o_Num for digit 0 of the new frame comes from the newly loaded value.
- Handshake:
  - Accept happens when i_Valid & o_Ready; i_Data is captured into pending and o_Ready drops next cycle.
  - o_Ready returns to 1 the cycle after the frame-boundary transfer.
  - While o_Ready is 0, i_Data is ignored.
  - If an accept coincides with a frame boundary while pending is empty, the data goes to pending only and is shown from the next frame.
  - The active register never changes mid-frame.
- Leading-zero blanking (i_Blank_Lz=1):
  - Digit k is blanked if nibbles k..NUM_DIGITS-1 of the active value are all 0.
  - Digit 0 is never blanked. Blanking is evaluated against the active value.
- Nibbles 0xA–0xF pass through unchanged; the decoder owns their glyph.
- Counter width is $clog2(max(SCAN_DIV,BLANK_CYC)+1). The counter resets to 0 on every state change.
- Reset asserted mid-operation: all outputs and state return to reset values immediately and asynchronously; pending data is discarded. After release, scanning restarts at idx 0 in S_BLANK.

Test Plan:
Bench configuration for all scenarios: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=2 (6-cycle slot, 24-cycle frame).
- Reset check:
  - During reset: o_Com=4'b1111, o_Num=0, o_Ready=1, o_Frame_Done=0.
  - After release: o_Com=4'b1110 on cycles 2–5, then 4'b1111 on cycles 6–7, o_Num=0 throughout.
- Load 16'h1234 mid-frame:
  - Current frame is unchanged (all 0).
  - Next frame shows o_Num 4,3,2,1 with o_Com 1110,1101,1011,0111.
  - Each digit is held 4 cycles with a 2-cycle all-ones gap.
- Back-to-back valid (16'h1111, then 16'h2222 held):
  - First is accepted; o_Ready=0 until the cycle after the boundary.
  - Second is accepted then; the frames show 1111, then 2222.
- LZ blanking with i_Blank_Lz=1:
  - 16'h0050: digits 2 and 3 keep o_Com=1111 and o_Digit_En=0 during their show; digits 0 and 1 are shown.
  - 16'h0000: only digit 0 is shown, with value 0.
  - 16'h0A00: digit 3 only is blanked.
- o_Frame_Done: single-cycle pulses spaced exactly 24 cycles apart, coinciding with the o_Num switch to digit 0.
- Async reset asserted mid-S_SHOW of digit 2 with pending full:
  - Outputs return to reset values without waiting for a clock edge.
  - After release, the display shows 0000 (pending discarded) and o_Ready=1.
